// File: rtl/sram_fifo_client.sv
// Requester side of the SRAM FIFO controller handshake: packs RX bytes into 16-bit
// write requests and unpacks words from read requests into a TX byte stream.
module sram_fifo_client #(
    parameter int         TIMEOUT_CYCLES = 255,
    parameter logic [7:0] PAD_BYTE       = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        rx_flush,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        req_write,
    output logic        req_read,
    output logic [15:0] wr_word,
    input  logic [15:0] rd_word,
    input  logic        hint,
    input  logic        dst_full,
    input  logic        src_empty,
    output logic        timeout_err,
    output logic        busy
);

    localparam int          TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_t;
    typedef enum logic {GRANT_READ, GRANT_WRITE} grant_t;

    state_t        state;
    grant_t        last_grant;
    logic [TW-1:0] timer;

    logic        byte_cnt, byte_cnt_n;
    logic [7:0]  lo_byte, lo_byte_n;
    logic [15:0] word, word_n;
    logic        word_valid, word_valid_n;

    logic [15:0] tx_word;
    logic [1:0]  tx_cnt;

    logic word_clear, tx_load, wr_ok, rd_ok;

    assign word_clear = (state == WR_WAIT) && hint;
    assign tx_load    = (state == RD_WAIT) && hint;
    assign rx_ready   = !word_valid;
    assign tx_valid   = (tx_cnt != 2'd0);
    assign tx_data    = (tx_cnt == 2'd2) ? tx_word[7:0] : tx_word[15:8];
    assign busy       = (state != IDLE);
    assign wr_ok      = word_valid && !dst_full;
    assign rd_ok      = !tx_valid && !src_empty;

    // A byte arriving with a flush is applied first; the flush then sees the result.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        byte_cnt_n   = byte_cnt;
        lo_byte_n    = lo_byte;
        word_n       = word;
        word_valid_n = word_valid;
        if (word_clear)
            word_valid_n = 1'b0;
        if (rx_valid && rx_ready) begin
            if (byte_cnt) begin
                word_n       = {rx_data, lo_byte};
                word_valid_n = 1'b1;
                byte_cnt_n   = 1'b0;
            end else begin
                lo_byte_n  = rx_data;
                byte_cnt_n = 1'b1;
            end
        end
        if (rx_flush && byte_cnt_n && !word_valid_n) begin
            word_n       = {PAD_BYTE, lo_byte_n};
            word_valid_n = 1'b1;
            byte_cnt_n   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            byte_cnt   <= 1'b0;
            lo_byte    <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            byte_cnt   <= byte_cnt_n;
            lo_byte    <= lo_byte_n;
            word       <= word_n;
            word_valid <= word_valid_n;
        end
    end

    // Read grants only happen with the buffer empty, so load and drain never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_word <= '0;
            tx_cnt  <= 2'd0;
        end else if (tx_load) begin
            tx_word <= rd_word;
            tx_cnt  <= 2'd2;
        end else if (tx_valid && tx_ready) begin
            tx_cnt <= tx_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= GRANT_READ;
            timer       <= '0;
            req_write   <= 1'b0;
            req_read    <= 1'b0;
            wr_word     <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                    // Contention goes to whichever side did not win last time.
                    if (wr_ok && (!rd_ok || last_grant == GRANT_READ)) begin
                        req_write  <= 1'b1;
                        wr_word    <= word;
                        last_grant <= GRANT_WRITE;
                        state      <= WR_WAIT;
                    end else if (rd_ok) begin
                        req_read   <= 1'b1;
                        last_grant <= GRANT_READ;
                        state      <= RD_WAIT;
                    end
                end
                WR_WAIT, RD_WAIT: begin
                    if (word_clear || tx_load) begin
                        req_write <= 1'b0;
                        req_read  <= 1'b0;
                        state     <= IDLE;
                    end else if (timer == TIMER_LAST) begin
                        // Abandon: a pending write word stays put and is retried.
                        req_write   <= 1'b0;
                        req_read    <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_fifo_client.sv
// Self-checking bench for sram_fifo_client: directed handshake scenarios plus a random
// byte stream run through a queue-based controller/packer model.
module tb_sram_fifo_client;

    localparam int         TIMEOUT = 255;
    localparam logic [7:0] PAD     = 8'h00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready, rx_flush;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic        req_write, req_read;
    logic [15:0] wr_word, rd_word;
    logic        hint, dst_full, src_empty, timeout_err, busy;

    int n_checks = 0;
    int n_pass   = 0;

    sram_fifo_client #(.TIMEOUT_CYCLES(TIMEOUT), .PAD_BYTE(PAD)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_flush(rx_flush),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .req_write(req_write), .req_read(req_read), .wr_word(wr_word), .rd_word(rd_word),
        .hint, .dst_full(dst_full), .src_empty(src_empty),
        .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        rx_data = 8'h00; rx_valid = 1'b0; rx_flush = 1'b0; tx_ready = 1'b0;
        rd_word = 16'h0000; hint = 1'b0; dst_full = 1'b0; src_empty = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        rx_data = b;
        rx_valid = 1'b1;
        while (!rx_ready && guard < 1000) begin
            tick();
            guard++;
        end
        if (!rx_ready) begin
            n_checks++;
            $display("FAIL send_byte_wait: rx_ready stuck at %b, required 1", rx_ready);
        end
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_checks++; if (rx_ready !== 1'b1) $display("FAIL reset_rx_ready: got %b want 1", rx_ready); else n_pass++;
        n_checks++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", tx_valid); else n_pass++;
        n_checks++; if ({req_write, req_read} !== 2'b00) $display("FAIL reset_req: got %b want 00", {req_write, req_read}); else n_pass++;
        n_checks++; if (wr_word !== 16'h0000) $display("FAIL reset_wr_word: got %h want 0000", wr_word); else n_pass++;
        n_checks++; if ({timeout_err, busy} !== 2'b00) $display("FAIL reset_err_busy: got %b want 00", {timeout_err, busy}); else n_pass++;
        apply_reset();
    endtask

    task automatic test_write();
        apply_reset();
        send_byte(8'h34);
        send_byte(8'h12);
        n_checks++; if (rx_ready !== 1'b0) $display("FAIL t1_rx_stall: got %b want 0", rx_ready); else n_pass++;
        tick();
        n_checks++; if (req_write !== 1'b1) $display("FAIL t1_req_write: got %b want 1", req_write); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (req_write !== 1'b1 || wr_word !== 16'h1234 || req_read !== 1'b0)
                $display("FAIL t1_hold[%0d]: got req=%b word=%h want req=1 word=1234", i, req_write, wr_word);
            else n_pass++;
            tick();
        end
        hint = 1'b1;
        tick();
        hint = 1'b0;
        n_checks++;
        if (req_write !== 1'b0 || rx_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL t1_done: got req=%b rx_ready=%b busy=%b want 0 1 0", req_write, rx_ready, busy);
        else n_pass++;
    endtask

    task automatic test_read();
        apply_reset();
        src_empty = 1'b0;
        tick();
        n_checks++; if (req_read !== 1'b1 || busy !== 1'b1) $display("FAIL t2_req_read: got req=%b busy=%b want 1 1", req_read, busy); else n_pass++;
        src_empty = 1'b1;
        rd_word = 16'hBEEF;
        hint = 1'b1;
        tick();
        hint = 1'b0;
        n_checks++;
        if (req_read !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'hEF)
            $display("FAIL t2_first: got req=%b txv=%b txd=%h want 0 1 ef", req_read, tx_valid, tx_data);
        else n_pass++;
        repeat (3) tick();
        n_checks++; if (tx_data !== 8'hEF || tx_valid !== 1'b1) $display("FAIL t2_stall: got txv=%b txd=%h want 1 ef", tx_valid, tx_data); else n_pass++;
        tx_ready = 1'b1;
        tick();
        n_checks++; if (tx_data !== 8'hBE || tx_valid !== 1'b1) $display("FAIL t2_second: got txv=%b txd=%h want 1 be", tx_valid, tx_data); else n_pass++;
        tick();
        tx_ready = 1'b0;
        n_checks++; if (tx_valid !== 1'b0) $display("FAIL t2_empty: got txv=%b want 0", tx_valid); else n_pass++;
    endtask

    task automatic test_arbitration();
        bit          want_write = 1'b1;
        bit          have_word  = 1'b0;
        logic [15:0] w = 16'h0000;
        logic [15:0] r;
        apply_reset();
        dst_full = 1'b1;
        for (int round = 0; round < 4; round++) begin
            if (!have_word) begin
                w = 16'($urandom);
                send_byte(w[7:0]);
                send_byte(w[15:8]);
                have_word = 1'b1;
            end
            dst_full = 1'b0;
            src_empty = 1'b0;
            tick();
            n_checks++;
            if (req_write !== want_write || req_read !== !want_write)
                $display("FAIL t3_grant[%0d]: got wr=%b rd=%b want wr=%b", round, req_write, req_read, want_write);
            else n_pass++;
            dst_full = 1'b1;
            src_empty = 1'b1;
            if (want_write) begin
                n_checks++; if (wr_word !== w) $display("FAIL t3_word[%0d]: got %h want %h", round, wr_word, w); else n_pass++;
                have_word = 1'b0;
            end
            r = 16'($urandom);
            rd_word = r;
            hint = 1'b1;
            tick();
            hint = 1'b0;
            if (!want_write) begin
                n_checks++; if (tx_data !== r[7:0]) $display("FAIL t3_rd[%0d]: got %h want %h", round, tx_data, r[7:0]); else n_pass++;
                tx_ready = 1'b1;
                repeat (2) tick();
                tx_ready = 1'b0;
            end
            want_write = !want_write;
        end
    endtask

    task automatic test_flush();
        apply_reset();
        send_byte(8'h5A);
        rx_flush = 1'b1;
        tick();
        rx_flush = 1'b0;
        tick();
        n_checks++; if (req_write !== 1'b1 || wr_word !== 16'h005A) $display("FAIL t4_pad: got req=%b word=%h want 1 005a", req_write, wr_word); else n_pass++;
        hint = 1'b1; tick(); hint = 1'b0;
        rx_flush = 1'b1; tick(); rx_flush = 1'b0;
        repeat (3) tick();
        n_checks++; if (req_write !== 1'b0 || busy !== 1'b0) $display("FAIL t4_empty_flush: got req=%b busy=%b want 0 0", req_write, busy); else n_pass++;
        rx_data = 8'h77; rx_valid = 1'b1; rx_flush = 1'b1;
        tick();
        rx_valid = 1'b0; rx_flush = 1'b0;
        tick();
        n_checks++; if (wr_word !== 16'h0077 || req_write !== 1'b1) $display("FAIL t4_same_cycle: got req=%b word=%h want 1 0077", req_write, wr_word); else n_pass++;
        hint = 1'b1; tick(); hint = 1'b0;
        send_byte(8'h11);
        rx_data = 8'h22; rx_valid = 1'b1; rx_flush = 1'b1;
        tick();
        rx_valid = 1'b0; rx_flush = 1'b0;
        tick();
        n_checks++; if (wr_word !== 16'h2211) $display("FAIL t4_complete_flush: got %h want 2211", wr_word); else n_pass++;
        hint = 1'b1; tick(); hint = 1'b0;
        repeat (3) tick();
        n_checks++; if (req_write !== 1'b0 || rx_ready !== 1'b1) $display("FAIL t4_no_extra: got req=%b rx_ready=%b want 0 1", req_write, rx_ready); else n_pass++;
    endtask

    task automatic test_timeout();
        int cyc;
        apply_reset();
        send_byte(8'hCD);
        send_byte(8'hAB);
        tick();
        cyc = 0;
        while (req_write && cyc < 400) begin
            tick();
            cyc++;
        end
        n_checks++; if (cyc !== TIMEOUT) $display("FAIL t5_wr_cycles: got %0d want %0d", cyc, TIMEOUT); else n_pass++;
        n_checks++; if ({timeout_err, busy} !== 2'b10) $display("FAIL t5_err_busy: got %b want 10", {timeout_err, busy}); else n_pass++;
        tick();
        n_checks++; if (req_write !== 1'b1 || wr_word !== 16'hABCD) $display("FAIL t5_retry: got req=%b word=%h want 1 abcd", req_write, wr_word); else n_pass++;
        hint = 1'b1; tick(); hint = 1'b0;
        src_empty = 1'b0;
        tick();
        src_empty = 1'b1;
        cyc = 0;
        while (req_read && cyc < 400) begin
            tick();
            cyc++;
        end
        n_checks++; if (cyc !== TIMEOUT) $display("FAIL t5_rd_cycles: got %0d want %0d", cyc, TIMEOUT); else n_pass++;
        n_checks++; if (tx_valid !== 1'b0 || timeout_err !== 1'b1) $display("FAIL t5_rd_state: got txv=%b err=%b want 0 1", tx_valid, timeout_err); else n_pass++;
    endtask

    task automatic test_async_reset();
        send_byte(8'h01);
        send_byte(8'h02);
        tick();
        n_checks++; if (req_write !== 1'b1) $display("FAIL t6_pre: got req=%b want 1", req_write); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (req_write !== 1'b0 || rx_ready !== 1'b1 || tx_valid !== 1'b0 || timeout_err !== 1'b0)
            $display("FAIL t6_async: got req=%b rx_ready=%b txv=%b err=%b want 0 1 0 0", req_write, rx_ready, tx_valid, timeout_err);
        else n_pass++;
        #2 rst_n = 1'b1;
        repeat (2) tick();
        n_checks++; if (req_write !== 1'b0 || busy !== 1'b0) $display("FAIL t6_discard: got req=%b busy=%b want 0 0", req_write, busy); else n_pass++;
    endtask

    // Controller emulated as a word queue; packer expectations built from byte arithmetic.
    task automatic test_random_stream();
        localparam int N_BYTES = 60;
        logic [15:0] exp_words[$];
        logic [15:0] mem[$];
        logic [7:0]  exp_tx[$];
        logic [15:0] w;
        logic [7:0]  lo_m = 8'h00, b;
        bit          held = 1'b0, flushed = 1'b0, pend = 1'b0, done = 1'b0;
        int          sent = 0, delay = 0, words_rd = 0;
        logic        pre_ready, pre_txv;
        logic [7:0]  pre_txd;
        apply_reset();
        for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
            pre_ready = rx_ready;
            pre_txv   = tx_valid;
            pre_txd   = tx_data;
            hint      = 1'b0;
            rx_valid  = (sent < N_BYTES) && ($urandom_range(0, 3) != 0);
            rx_data   = 8'($urandom);
            if (sent < N_BYTES) rx_flush = ($urandom_range(0, 9) == 0);
            else begin
                rx_flush = !flushed;
                flushed  = 1'b1;
            end
            tx_ready  = 1'($urandom_range(0, 1));
            dst_full  = (mem.size() >= 4);
            src_empty = (mem.size() == 0);
            if ((req_write || req_read) && !pend) begin
                pend  = 1'b1;
                delay = $urandom_range(0, 3);
            end
            if (pend) begin
                if (delay == 0) begin
                    hint = 1'b1;
                    pend = 1'b0;
                    if (req_write) begin
                        n_checks++;
                        if (exp_words.size() == 0) $display("FAIL rand_wr_word: got %h with no word expected", wr_word);
                        else begin
                            w = exp_words.pop_front();
                            if (wr_word !== w) $display("FAIL rand_wr_word: got %h want %h", wr_word, w);
                            else n_pass++;
                        end
                        mem.push_back(wr_word);
                    end else if (mem.size() == 0) begin
                        n_checks++;
                        $display("FAIL rand_rd_empty: read request with src_empty, got 1 want 0");
                    end else begin
                        rd_word = mem.pop_front();
                        exp_tx.push_back(rd_word[7:0]);
                        exp_tx.push_back(rd_word[15:8]);
                        words_rd++;
                    end
                end else delay--;
            end
            tick();
            if (rx_valid && pre_ready) begin
                sent++;
                if (held) begin
                    exp_words.push_back({rx_data, lo_m});
                    held = 1'b0;
                end else begin
                    lo_m = rx_data;
                    held = 1'b1;
                end
            end
            if (rx_flush && held) begin
                exp_words.push_back({PAD, lo_m});
                held = 1'b0;
            end
            if (pre_txv && tx_ready) begin
                n_checks++;
                if (exp_tx.size() == 0) $display("FAIL rand_tx: got %h with no byte expected", pre_txd);
                else begin
                    b = exp_tx.pop_front();
                    if (pre_txd !== b) $display("FAIL rand_tx: got %h want %h", pre_txd, b);
                    else n_pass++;
                end
            end
            done = (sent >= N_BYTES) && flushed && !held && exp_words.size() == 0 &&
                   mem.size() == 0 && exp_tx.size() == 0 && !busy && !tx_valid;
        end
        rx_valid = 1'b0; rx_flush = 1'b0; tx_ready = 1'b0; hint = 1'b0;
        n_checks++; if (!done) $display("FAIL rand_drain: stream not drained, got %0d bytes sent want %0d", sent, N_BYTES); else n_pass++;
        n_checks++; if (words_rd < 30) $display("FAIL rand_words: got %0d words read want >= 30", words_rd); else n_pass++;
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL rand_err: got %b want 0", timeout_err); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_arbitration();
        test_flush();
        test_timeout();
        test_async_reset();
        test_random_stream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
